stopwatch_core: RTL and testbench

// - MM:SS BCD stopwatch counter directly downstream of the crystal frequency divider.
// - Consumes the divided 1 Hz clock (clk_1hz) as a data signal; rising edge detected in the clk domain.
// - Start/stop and clear come in as one-cycle debounced pulses.
// - Drives 4 BCD digits to the seven-segment scan stage.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_core_bcd_digit_cnt.sv | 37 +++
 rtl/stopwatch_core.sv | 188 ++++++++++++++++++
 tb/tb_stopwatch_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the MM:SS stopwatch slice.
//   state_t   : stopwatch FSM encoding (IDLE / RUN / PAUSE)
//   bcd_t     : one BCD digit
//   SEC_U_MAX : top value of the seconds-units digit
//   SEC_T_MAX : top value of the seconds-tens digit
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t SEC_U_MAX = 4'd9;
  localparam bcd_t SEC_T_MAX = 4'd5;
  localparam bcd_t BCD_TOP   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/stopwatch_core_bcd_digit_cnt.sv
// bcd_digit_cnt: one mod-(max+1) BCD digit of the stopwatch carry chain.
//   clk   in  system clock
//   rst   in  asynchronous active-high reset (digit -> 0)
//   inc   in  advance the digit by one this cycle
//   clr   in  synchronous clear to 0, overrides inc
//   max   in  highest legal value of this digit (may change at run time)
//   q     out registered digit value
//   carry out inc while the digit sits at max (next digit must advance)
module bcd_digit_cnt
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  bcd_t max,
  output bcd_t q,
  output logic carry
);

  logic at_max;

  assign at_max = (q == max);
  assign carry  = inc & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      // >= guards against a run-time max dropping below the current value
      q <= (q >= max) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch fed by the divided 1 Hz clock.
//   clk        in  system clock, single domain
//   rst        in  asynchronous active-high reset
//   clk_1hz    in  divided clock, treated as data; rising edge -> one tick
//   start_stop in  one-cycle pulse: IDLE->RUN, RUN<->PAUSE
//   clear      in  one-cycle pulse: digits to 00:00, back to IDLE (top priority)
//   lap        in  one-cycle pulse: toggles display freeze (STOPWATCH_LAP_EN only)
//   min_t/min_u/sec_t/sec_u out  displayed BCD digits
//   running    out high while in RUN
//   wrap       out one-cycle pulse when the count passes MIN_MAX:59
// Parameters: MIN_MAX (highest minutes value, 1..99), ROLLOVER (1: wrap to
// 00:00 and keep running, 0: hold MIN_MAX:59 and pause).
// Build option: define STOPWATCH_LAP_EN to enable the lap freeze display.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_MAX  = 59,
  parameter bit          ROLLOVER = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_1hz,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  output logic [BCD_W-1:0] min_t,
  output logic [BCD_W-1:0] min_u,
  output logic [BCD_W-1:0] sec_t,
  output logic [BCD_W-1:0] sec_u,
  output logic             running,
  output logic             wrap
);

  localparam bcd_t MT_MAX = bcd_t'(MIN_MAX / 10);
  localparam bcd_t MU_TOP = bcd_t'(MIN_MAX % 10);

  state_t state;
  logic   clk_1hz_d;
  logic   tick;

  bcd_t   live_su, live_st, live_mu, live_mt;
  bcd_t   mu_max;
  logic   c_su, c_st, c_mu, carry_unused;
  logic   at_max;
  logic   count_inc;
  logic   wrap_evt;

  // Reset value 1 so a clk_1hz already high at reset release is not a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_1hz_d <= 1'b1;
    end else begin
      clk_1hz_d <= clk_1hz;
    end
  end

  assign tick = clk_1hz & ~clk_1hz_d;

  // Minutes units only run to 9 except in the last decade of minutes.
  assign mu_max = (live_mt == MT_MAX) ? MU_TOP : BCD_TOP;

  assign at_max = (live_su == SEC_U_MAX) && (live_st == SEC_T_MAX) &&
                  (live_mu == mu_max)    && (live_mt == MT_MAX);

  // With ROLLOVER=0 the chain is simply not advanced at the top value,
  // so the digits hold MIN_MAX:59 without a separate load path.
  assign wrap_evt  = (state == ST_RUN) && tick && !clear && at_max;
  assign count_inc = (state == ST_RUN) && tick && !clear && !(at_max && !ROLLOVER);

  bcd_digit_cnt u_sec_u (
    .clk   (clk),
    .rst   (rst),
    .inc   (count_inc),
    .clr   (clear),
    .max   (SEC_U_MAX),
    .q     (live_su),
    .carry (c_su)
  );

  bcd_digit_cnt u_sec_t (
    .clk   (clk),
    .rst   (rst),
    .inc   (c_su),
    .clr   (clear),
    .max   (SEC_T_MAX),
    .q     (live_st),
    .carry (c_st)
  );

  bcd_digit_cnt u_min_u (
    .clk   (clk),
    .rst   (rst),
    .inc   (c_st),
    .clr   (clear),
    .max   (mu_max),
    .q     (live_mu),
    .carry (c_mu)
  );

  bcd_digit_cnt u_min_t (
    .clk   (clk),
    .rst   (rst),
    .inc   (c_mu),
    .clr   (clear),
    .max   (MT_MAX),
    .q     (live_mt),
    .carry (carry_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= wrap_evt;
      if (clear) begin
        state   <= ST_IDLE;
        running <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_stop) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (start_stop || (wrap_evt && !ROLLOVER)) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (start_stop) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic frozen;
  bcd_t lap_su, lap_st, lap_mu, lap_mt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen <= 1'b0;
      lap_su <= '0;
      lap_st <= '0;
      lap_mu <= '0;
      lap_mt <= '0;
    end else if (clear) begin
      frozen <= 1'b0;
    end else if (lap && (state != ST_IDLE)) begin
      frozen <= ~frozen;
      if (!frozen) begin
        lap_su <= live_su;
        lap_st <= live_st;
        lap_mu <= live_mu;
        lap_mt <= live_mt;
      end
    end
  end

  // Display select between two register banks; the live count keeps going.
  assign sec_u = frozen ? lap_su : live_su;
  assign sec_t = frozen ? lap_st : live_st;
  assign min_u = frozen ? lap_mu : live_mu;
  assign min_t = frozen ? lap_mt : live_mt;
`else
  logic lap_unused;
  assign lap_unused = lap;

  assign sec_u = live_su;
  assign sec_t = live_st;
  assign min_u = live_mu;
  assign min_t = live_mt;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1hz = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;

  logic [3:0] mt_r, mu_r, st_r, su_r;
  logic [3:0] mt_h, mu_h, st_h, su_h;
  logic       run_r, wrap_r, run_h, wrap_h;
  logic [15:0] dig_r, dig_h;

  int total = 0;
  int bad   = 0;

  assign dig_r = {mt_r, mu_r, st_r, su_r};
  assign dig_h = {mt_h, mu_h, st_h, su_h};

  always #5 clk = ~clk;

  stopwatch_core #(.MIN_MAX(59), .ROLLOVER(1'b1)) dut_r (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .start_stop(start_stop),
    .clear(clear), .lap(lap),
    .min_t(mt_r), .min_u(mu_r), .sec_t(st_r), .sec_u(su_r),
    .running(run_r), .wrap(wrap_r)
  );

  stopwatch_core #(.MIN_MAX(59), .ROLLOVER(1'b0)) dut_h (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .start_stop(start_stop),
    .clear(clear), .lap(lap),
    .min_t(mt_h), .min_u(mu_h), .sec_t(st_h), .sec_u(su_h),
    .running(run_h), .wrap(wrap_h)
  );

  typedef struct {
    logic        ss;
    logic        clr;
    logic        hz;
    logic [15:0] dig;
    logic        run;
    logic        wr;
  } vec_t;

  vec_t vecs [29];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    clk_1hz = 1'b1;
    step();
    clk_1hz = 1'b0;
    step();
  endtask

  task automatic chk_both(input string nm, input logic [15:0] dig, input logic run, input logic wr);
    chk({nm, "_dig_r"}, dig_r, dig);
    chk({nm, "_dig_h"}, dig_h, dig);
    chk({nm, "_run_r"}, 16'(run_r), 16'(run));
    chk({nm, "_run_h"}, 16'(run_h), 16'(run));
    chk({nm, "_wrap_r"}, 16'(wrap_r), 16'(wr));
    chk({nm, "_wrap_h"}, 16'(wrap_h), 16'(wr));
  endtask

  initial begin
    //            ss  clr hz  digits     run wrap
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 16'h0006, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[26] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[28] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};

    // Reset with clk_1hz held high, release.
    repeat (3) step();
    rst = 1'b0;
    chk_both("reset", 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 29; i++) begin
      start_stop = vecs[i].ss;
      clear      = vecs[i].clr;
      clk_1hz    = vecs[i].hz;
      step();
      chk_both($sformatf("vec%0d", i), vecs[i].dig, vecs[i].run, vecs[i].wr);
    end
    start_stop = 1'b0;
    clear      = 1'b0;

    // Long count: seconds carry, minutes carry, top of range.
    clk_1hz    = 1'b0;
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    repeat (59) tick();
    chk_both("c0059", 16'h0059, 1'b1, 1'b0);
    tick();
    chk_both("c0100", 16'h0100, 1'b1, 1'b0);
    repeat (540) tick();
    chk_both("c1000", 16'h1000, 1'b1, 1'b0);
    repeat (2999) tick();
    chk_both("c5959", 16'h5959, 1'b1, 1'b0);

    clk_1hz = 1'b1;
    step();
    chk("top_dig_r", dig_r, 16'h0000);
    chk("top_wrap_r", 16'(wrap_r), 16'd1);
    chk("top_run_r", 16'(run_r), 16'd1);
    chk("top_dig_h", dig_h, 16'h5959);
    chk("top_wrap_h", 16'(wrap_h), 16'd1);
    chk("top_run_h", 16'(run_h), 16'd0);
    clk_1hz = 1'b0;
    step();
    chk("post_wrap_r", 16'(wrap_r), 16'd0);
    chk("post_wrap_h", 16'(wrap_h), 16'd0);
    tick();
    chk("after_dig_r", dig_r, 16'h0001);
    chk("after_dig_h", dig_h, 16'h5959);
    chk("after_run_h", 16'(run_h), 16'd0);

    // Asynchronous reset mid-count with clk_1hz high.
    clk_1hz = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dig_r", dig_r, 16'h0000);
    step();
    step();
    rst = 1'b0;
    step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    step();
    chk_both("rst_no_tick", 16'h0000, 1'b1, 1'b0);

    // Lap freeze.
    clk_1hz = 1'b0;
    step();
    repeat (12) tick();
    chk_both("lap_pre", 16'h0012, 1'b1, 1'b0);
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk_both("lap_on", 16'h0012, 1'b1, 1'b0);
    repeat (3) tick();
`ifdef STOPWATCH_LAP_EN
    chk_both("lap_hold", 16'h0012, 1'b1, 1'b0);
`else
    chk_both("lap_hold", 16'h0015, 1'b1, 1'b0);
`endif
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk_both("lap_off", 16'h0015, 1'b1, 1'b0);
    lap = 1'b1;
    step();
    lap = 1'b0;
    tick();
`ifdef STOPWATCH_LAP_EN
    chk_both("lap2_hold", 16'h0015, 1'b1, 1'b0);
`else
    chk_both("lap2_hold", 16'h0016, 1'b1, 1'b0);
`endif
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_both("lap_clear", 16'h0000, 1'b0, 1'b0);
    tick();
    chk_both("idle_after_clear", 16'h0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
